// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - shares one req/gnt/rvalid memory port between fetch (I) and LSU (D)
// D has fixed priority over I, with a starvation guard; in-order responses are routed by an ID FIFO.
module miriscv_mem_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              proto_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_e;

    state_e                     state_q, state_d;
    logic                       lock_q, lock_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [SC_W-1:0]            starve_q, starve_d;

    logic sel;
    logic req;
    logic accept;
    logic rsp_pop;
    logic head;
    logic fifo_empty;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        sel     = PORT_I;
        req     = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if ((count_q < CNT_MAX) && (instr_req_i || data_req_i)) begin
                        req = 1'b1;
                        if ((starve_q == SC_MAX) && instr_req_i) begin
                            sel = PORT_I;
                        end else if (data_req_i) begin
                            sel = PORT_D;
                        end else begin
                            sel = PORT_I;
                        end
                        if (!mem_gnt_i) begin
                            state_d = WAIT_GNT;
                            lock_d  = sel;
                        end
                    end
                end
                WAIT_GNT: begin
                    // Issue was already admitted by the count gate; only wait for gnt.
                    req = 1'b1;
                    sel = lock_q;
                    if (mem_gnt_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_o   = req;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (req) begin
            if (sel == PORT_D) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign accept      = req & mem_gnt_i;
    assign instr_gnt_o = accept & (sel == PORT_I);
    assign data_gnt_o  = accept & (sel == PORT_D);

    assign fifo_empty     = (count_q == '0);
    assign head           = fifo_q[rptr_q];
    assign rsp_pop        = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign proto_err_o    = mem_rvalid_i & fifo_empty & ~rst_i;
    assign instr_rvalid_o = rsp_pop & (head == PORT_I);
    assign data_rvalid_o  = rsp_pop & (head == PORT_D);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    always_comb begin
        fifo_d  = fifo_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (accept) begin
            fifo_d[wptr_q] = sel;
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (rsp_pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
        end
        case ({accept, rsp_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!instr_req_i || instr_gnt_o) begin
            starve_d = '0;
        end else if (data_gnt_o && (starve_q != SC_MAX)) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lock_q   <= PORT_I;
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fifo_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fifo_q   <= fifo_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb/tb_miriscv_mem_arbiter.sv - scoreboard bench for miriscv_mem_arbiter
// Directed stimulus pushes expected grants/responses; a negedge monitor pops and compares.
module tb_miriscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_gnt, instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        proto_err;

    always #5 clk = ~clk;

    miriscv_mem_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .proto_err_o    (proto_err)
    );

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        we;
    } gnt_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   perr_exp = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (instr_gnt || data_gnt) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", {30'd0, data_gnt, instr_gnt}, 32'd0);
            end else begin
                gnt_t e;
                e = gq.pop_front();
                chk("gnt_onehot", {31'd0, instr_gnt & data_gnt}, 32'd0);
                chk("gnt_port", {31'd0, data_gnt}, {31'd0, e.port});
                chk("gnt_addr", mem_addr, e.addr);
                chk("gnt_we", {31'd0, mem_we}, {31'd0, e.we});
                chk("gnt_be", {28'd0, mem_be}, e.port ? {28'd0, data_be} : 32'hF);
            end
        end
        if (instr_rvalid || data_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, data_rvalid, instr_rvalid}, 32'd0);
            end else begin
                rsp_t r;
                r = rq.pop_front();
                chk("rsp_onehot", {31'd0, instr_rvalid & data_rvalid}, 32'd0);
                chk("rsp_port", {31'd0, data_rvalid}, {31'd0, r.port});
                chk("rsp_data", r.port ? data_rdata : instr_rdata, r.data);
            end
        end
        if (proto_err) begin
            checks++;
            if (perr_exp == 0) begin
                errors++;
                $display("FAIL unexpected_proto_err: got 1 expected 0 at %0t", $time);
            end else begin
                perr_exp--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req  = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic push_g(input logic port, input logic [31:0] addr, input logic we);
        gnt_t g;
        g.port = port;
        g.addr = addr;
        g.we   = we;
        gq.push_back(g);
    endtask

    task automatic push_r(input logic port, input logic [31:0] data);
        rsp_t r;
        r.port = port;
        r.data = data;
        rq.push_back(r);
    endtask

    logic [6:0] starve_seq;

    initial begin
        data_be = 4'hF;
        tick();
        tick();
        @(negedge clk);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_gnt", {30'd0, instr_gnt, data_gnt}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
        tick();

        // 1: single fetch, response one cycle later
        instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
        push_g(1'b0, 32'h100, 1'b0);
        tick();
        idle_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        push_r(1'b0, 32'h13);
        @(negedge clk);
        chk("t1_data_rvalid", {31'd0, data_rvalid}, 32'd0);
        tick();
        idle_inputs();
        tick();

        // 2: simultaneous I and D, D first
        instr_req = 1'b1; instr_addr = 32'h200;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'h3; data_addr = 32'h300; data_wdata = 32'hAA;
        mem_gnt = 1'b1;
        push_g(1'b1, 32'h300, 1'b1);
        @(negedge clk);
        chk("t2_wdata", mem_wdata, 32'hAA);
        tick();
        data_req = 1'b0; data_we = 1'b0; data_be = 4'hF;
        push_g(1'b0, 32'h200, 1'b0);
        @(negedge clk);
        chk("t2_i_wdata_zero", mem_wdata, 32'd0);
        tick();
        idle_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'hD0;
        push_r(1'b1, 32'hD0);
        tick();
        mem_rdata = 32'h10;
        push_r(1'b0, 32'h10);
        tick();
        idle_inputs();
        tick();

        // 3: starvation guard, 4 D then I then D
        starve_seq = 7'b1101111;
        instr_addr = 32'h400; data_addr = 32'h500;
        for (int k = 0; k <= 7; k++) begin
            instr_req  = (k < 7);
            data_req   = (k < 7);
            mem_gnt    = (k < 7);
            mem_rvalid = (k > 0);
            mem_rdata  = 32'h3000 + k;
            if (k < 7) push_g(starve_seq[k], starve_seq[k] ? 32'h500 : 32'h400, 1'b0);
            if (k > 0) push_r(starve_seq[k-1], 32'h3000 + k);
            tick();
        end
        idle_inputs();
        tick();

        // 4: outstanding limit, strict slot release
        data_addr = 32'h600;
        for (int k = 0; k <= 8; k++) begin
            data_req   = (k <= 6);
            mem_gnt    = (k <= 6);
            mem_rvalid = (k >= 5 && k != 6);
            mem_rdata  = 32'h40 + k;
            if (k == 0 || k == 1 || k == 6) push_g(1'b1, 32'h600, 1'b0);
            if (mem_rvalid) push_r(1'b1, 32'h40 + k);
            @(negedge clk);
            if (k >= 2 && k <= 5) chk("t4_blocked_req", {31'd0, mem_req}, 32'd0);
            if (k == 6) chk("t4_reissue_req", {31'd0, mem_req}, 32'd1);
            tick();
        end
        idle_inputs();
        tick();

        // 5: locked D while waiting for gnt, I arrives mid-wait
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h700; data_wdata = 32'h77;
        instr_addr = 32'h800;
        for (int k = 0; k <= 4; k++) begin
            instr_req = (k >= 1);
            data_req  = (k <= 3);
            data_we   = (k <= 3);
            mem_gnt   = (k >= 3);
            if (k == 3) push_g(1'b1, 32'h700, 1'b1);
            if (k == 4) push_g(1'b0, 32'h800, 1'b0);
            @(negedge clk);
            if (k <= 3) chk("t5_locked_addr", mem_addr, 32'h700);
            tick();
        end
        idle_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'hA5;
        push_r(1'b1, 32'hA5);
        tick();
        mem_rdata = 32'h5A;
        push_r(1'b0, 32'h5A);
        tick();
        idle_inputs();
        tick();

        // 6: reset with a request in flight, then a late rvalid
        instr_req = 1'b1; instr_addr = 32'h900; mem_gnt = 1'b1;
        push_g(1'b0, 32'h900, 1'b0);
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        perr_exp++;
        @(negedge clk);
        chk("t6_proto_err", {31'd0, proto_err}, 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("t6_proto_err_pulse", {31'd0, proto_err}, 32'd0);
        tick();
        data_addr = 32'hA00;
        for (int k = 0; k <= 4; k++) begin
            data_req   = (k <= 2);
            mem_gnt    = (k <= 2);
            mem_rvalid = (k >= 3);
            mem_rdata  = 32'hE0 + k;
            if (k <= 1) push_g(1'b1, 32'hA00, 1'b0);
            if (k >= 3) push_r(1'b1, 32'hE0 + k);
            @(negedge clk);
            if (k == 2) chk("t6_count_full", {31'd0, mem_req}, 32'd0);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        chk("gnt_queue_drained", gq.size(), 32'd0);
        chk("rsp_queue_drained", rq.size(), 32'd0);
        chk("proto_err_seen", perr_exp, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
